// File: rtl/vram_sched_pkg.sv
// Shared types and helpers for the VRAM access scheduler: FSM state encoding,
// default geometry and the video slot decode.
package vram_sched_pkg;

    localparam int VRAM_ADDR_W    = 10;
    localparam int VRAM_SLOT_LOG2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } sched_state_t;

    // A video slot is every 2^slot_log2 pixels of active display.
    function automatic logic vid_slot_f(input logic [7:0] h, input logic hbl,
                                        input logic vbl, input int slot_log2);
        logic [7:0] mask;
        mask = 8'((9'd1 << slot_log2) - 9'd1);
        return ~hbl & ~vbl & ((h & mask) == 8'd0);
    endfunction

endpackage

// File: rtl/vram_fetch_pipe.sv
// Video tile fetch capture: the slot flag is delayed to line up with the RAM's
// one-cycle read latency, then the data and a one-cycle valid strobe are registered.
module vram_fetch_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       vid_slot,
    input  logic [7:0] ram_dout,
    output logic [7:0] vid_dout,
    output logic       vid_valid
);

    logic slot_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_d1   <= 1'b0;
            vid_valid <= 1'b0;
            vid_dout  <= 8'd0;
        end else begin
            slot_d1   <= vid_slot;
            vid_valid <= slot_d1;
            if (slot_d1) begin
                vid_dout <= ram_dout;
            end
        end
    end

endmodule

// File: rtl/vram_access_sched.sv
// Single-port VRAM time-slot scheduler: video fetch owns fixed slots, the CPU
// fills the rest behind a Z80 WAIT. Optional `VRAM_WAIT_STATS_EN adds max_wait.
module vram_access_sched
    import vram_sched_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int SLOT_LOG2 = VRAM_SLOT_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        h,
    input  logic              hbl,
    input  logic              vbl,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait_n,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
`ifdef VRAM_WAIT_STATS_EN
    ,
    output logic [7:0]        max_wait
`endif
);

    sched_state_t state;
    logic         vid_slot;
    logic         issue;
    logic         rd_we;

    assign vid_slot = vid_slot_f(h, hbl, vbl, SLOT_LOG2);

    // Issue is suppressed under reset so a held write is not committed twice.
    assign issue = ~reset & (state == ST_IDLE) & cpu_req & ~vid_slot;

    assign cpu_wait_n = ~(cpu_req & (state != ST_ACK));

    always_comb begin
        ram_addr = cpu_addr;
        ram_we   = 1'b0;
        ram_din  = cpu_din;
        if (vid_slot) begin
            ram_addr = vid_addr;
        end else if (issue) begin
            ram_we = cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cpu_dout <= 8'd0;
            rd_we    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        rd_we <= cpu_we;
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (!rd_we) begin
                        cpu_dout <= ram_dout;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (!cpu_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    vram_fetch_pipe u_fetch_pipe (
        .clk       (clk),
        .reset     (reset),
        .vid_slot  (vid_slot),
        .ram_dout  (ram_dout),
        .vid_dout  (vid_dout),
        .vid_valid (vid_valid)
    );

`ifdef VRAM_WAIT_STATS_EN
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nx;

    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (cpu_req && (state != ST_ACK) && (wait_cnt != 8'hFF)) begin
            wait_cnt_nx = wait_cnt + 8'd1;
        end
    end

    // The RD cycle is the last stalled one, so its count is the completed total.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            max_wait <= 8'd0;
        end else if (state == ST_RD) begin
            if (wait_cnt_nx > max_wait) begin
                max_wait <= wait_cnt_nx;
            end
            wait_cnt <= 8'd0;
        end else if ((state == ST_IDLE) && !cpu_req) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_vram_access_sched.sv
// Directed plus randomized bench for vram_access_sched with a slot-rule reference
// model, a video fetch scoreboard and a behavioural VRAM.
module tb_vram_access_sched;

    localparam int SLOT_LOG2 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] h;
    logic       hbl, vbl;
    logic       cpu_req, cpu_we;
    logic [9:0] cpu_addr, vid_addr, ram_addr;
    logic [7:0] cpu_din, cpu_dout, vid_dout, ram_din, ram_dout;
    logic       cpu_wait_n, vid_valid, ram_we;
`ifdef VRAM_WAIT_STATS_EN
    logic [7:0] max_wait;
`endif

    logic [7:0] mem[1024];
    logic [7:0] ref_mem[1024];
    logic [7:0] exp_q[$];
    int         due_q[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       exp_we;
    logic [7:0] exp_cpu_dout;
    int         exp_max;
    bit         vid_dir;

    vram_access_sched dut (
        .clk        (clk),
        .reset      (reset),
        .h          (h),
        .hbl        (hbl),
        .vbl        (vbl),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .vid_addr   (vid_addr),
        .vid_dout   (vid_dout),
        .vid_valid  (vid_valid),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
`ifdef VRAM_WAIT_STATS_EN
        ,
        .max_wait   (max_wait)
`endif
    );

    // clock / VRAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic bit ref_slot(input logic [7:0] hh, input logic hb, input logic vb);
        return !hb && !vb && ((int'(hh) % (1 << SLOT_LOG2)) == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        h = h + 8'd1;
        vid_addr = vid_dir ? {2'b00, h} : 10'($urandom);
    endtask

    // Per-cycle checks: video scoreboard, RAM port mux and write strobe.
    task automatic common();
        bit slot;
        #1;
        slot = ref_slot(h, hbl, vbl);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            check("vid_valid", vid_valid, 1);
            check("vid_dout", vid_dout, exp_q[0]);
            due_q.delete(0);
            exp_q.delete(0);
        end else begin
            check("vid_valid", vid_valid, 0);
        end
        check("ram_addr", ram_addr, slot ? vid_addr : cpu_addr);
        check("ram_we", ram_we, exp_we);
        if (reset) begin
            exp_q.delete();
            due_q.delete();
        end else if (slot) begin
            exp_q.push_back(ref_mem[vid_addr]);
            due_q.push_back(cyc + 2);
        end
    endtask

    task automatic check_stats();
`ifdef VRAM_WAIT_STATS_EN
        check("max_wait", max_wait, exp_max);
`endif
    endtask

    // CPU transaction: the model predicts the issue cycle from the slot rule.
    task automatic xfer(input logic we, input logic [9:0] addr, input logic [7:0] din, input bit drop);
        int k;
        int cnt;
        logic [7:0] hk;
        logic exp_wn;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_din = din;
        k = 0;
        hk = h;
        while (ref_slot(hk, hbl, vbl) && k < 8) begin
            k++;
            hk = hk + 8'd1;
        end
        for (int i = 0; i <= k + 2; i++) begin
            if (drop && i == k + 1) cpu_req = 1'b0;
            exp_we = we && (i == k);
            common();
            exp_wn = (i <= k) ? 1'b0 : (i == k + 1) ? drop : 1'b1;
            check("wait_n", cpu_wait_n, exp_wn);
            if (i == k) begin
                if (we) begin
                    check("ram_din", ram_din, din);
                    ref_mem[addr] = din;
                end else begin
                    exp_cpu_dout = ref_mem[addr];
                end
            end
            if (i == k + 2) check("cpu_dout", cpu_dout, exp_cpu_dout);
            exp_we = 1'b0;
            advance();
        end
        if (!drop) begin
            cpu_req = 1'b0;
            common();
            check("wait_n_release", cpu_wait_n, 1);
            advance();
        end
        cnt = drop ? k + 1 : k + 2;
        if (cnt > exp_max) exp_max = cnt;
        check_stats();
    endtask

    initial begin
        logic [7:0] prev;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1; h = 8'd0; hbl = 1'b1; vbl = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_din = 8'd0;
        vid_addr = 10'd0; vid_dir = 1'b0;
        exp_we = 1'b0; exp_cpu_dout = 8'd0; exp_max = 0;

        // reset state
        common(); advance();
        common(); advance();
        reset = 1'b0;
        common();
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_vid_dout", vid_dout, 0);
        check("rst_wait_n", cpu_wait_n, 1);
        check_stats();
        advance();

        // CPU read during vertical blank
        hbl = 1'b0; vbl = 1'b1;
        mem[10'h155] = 8'hA5; ref_mem[10'h155] = 8'hA5;
        xfer(1'b0, 10'h155, 8'h00, 1'b0);
        check("vbl_read_data", cpu_dout, 8'hA5);

        // Collision with a video slot in active display
        hbl = 1'b0; vbl = 1'b0; h = 8'h40;
        xfer(1'b0, 10'h0AB, 8'h00, 1'b0);

        // CPU write in a free slot, then read back
        hbl = 1'b0; vbl = 1'b1;
        prev = cpu_dout;
        xfer(1'b1, 10'h2AA, 8'h3C, 1'b0);
        check("write_keeps_dout", cpu_dout, prev);
        xfer(1'b0, 10'h2AA, 8'h00, 1'b0);
        check("readback", cpu_dout, 8'h3C);

        // Video pipeline with known tile data, then horizontal blank
        hbl = 1'b0; vbl = 1'b0; vid_dir = 1'b1;
        mem[10'h010] = 8'h11; ref_mem[10'h010] = 8'h11;
        mem[10'h014] = 8'h22; ref_mem[10'h014] = 8'h22;
        mem[10'h018] = 8'h33; ref_mem[10'h018] = 8'h33;
        h = 8'h0E; vid_addr = {2'b00, h};
        begin
            int pulses = 0;
            for (int i = 0; i < 14; i++) begin
                common();
                if (vid_valid === 1'b1) pulses++;
                advance();
            end
            check("vid_pulses", pulses, 3);
            hbl = 1'b1;
            pulses = 0;
            for (int i = 0; i < 10; i++) begin
                common();
                if (vid_valid === 1'b1) pulses++;
                advance();
            end
            check("hbl_pulses", pulses, 0);
        end
        vid_dir = 1'b0;

        // Request dropped while blocked by a video slot: no access
        hbl = 1'b0; vbl = 1'b0; h = 8'h20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h301; cpu_din = 8'hEE;
        common();
        check("drop_idle_wait", cpu_wait_n, 0);
        advance();
        cpu_req = 1'b0;
        common();
        check("drop_idle_rel", cpu_wait_n, 1);
        advance();
        xfer(1'b0, 10'h301, 8'h00, 1'b0);

        // Request dropped during the read cycle
        hbl = 1'b0; vbl = 1'b1;
        xfer(1'b0, 10'h302, 8'h00, 1'b1);

        // Reset during the issue cycle of a held write
        hbl = 1'b0; vbl = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0F0; cpu_din = 8'h77;
        reset = 1'b1;
        common();
        advance();
        exp_cpu_dout = 8'd0;
        exp_max = 0;
        common();
        check("rstw_cpu_dout", cpu_dout, 0);
        check("rstw_vid_valid", vid_valid, 0);
        check("rstw_wait_n", cpu_wait_n, 0);
        check_stats();
        advance();
        reset = 1'b0;
        xfer(1'b1, 10'h0F0, 8'h77, 1'b0);
        xfer(1'b0, 10'h0F0, 8'h00, 1'b0);
        check("rstw_readback", cpu_dout, 8'h77);

        // Randomized traffic against the slot-rule model
        for (int t = 0; t < 60; t++) begin
            int gap;
            hbl = ($urandom_range(0, 3) == 0);
            vbl = ($urandom_range(0, 3) == 0);
            h = 8'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                common();
                advance();
            end
            xfer(1'($urandom_range(0, 1)), 10'h300 + 10'($urandom_range(0, 15)),
                 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            common();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_access_sched.md
Name: vram_access_sched

Overview:
- Time-slot scheduler for the single-port tile/colour VRAM, shared between CPU accesses and the video tile fetch.
- Driven by the video timing counters: `h`, `hbl`, `vbl`.
- Video fetch gets fixed, non-negotiable slots. The CPU uses the remaining slots and is stalled through a Z80-style WAIT handshake.
- Sits between the CPU bus decode, the tile address generator and the VRAM instance.

Parameters:
- ADDR_W, 10, VRAM address width.
- SLOT_LOG2, 2, video slot period is 2^SLOT_LOG2 pixel clocks; a video slot occurs when `h[SLOT_LOG2-1:0]==0`.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- h  in  8  horizontal count from video timing
- hbl  in  1  horizontal blank, active high
- vbl  in  1  vertical blank, active high
- cpu_req  in  1  CPU VRAM select, held high until acknowledged
- cpu_we  in  1  1 = write, 0 = read; valid while `cpu_req` is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  registered CPU read data
- cpu_wait_n  out  1  Z80 WAIT, active low
- vid_addr  in  ADDR_W  tile fetch address
- vid_dout  out  8  registered fetch data
- vid_valid  out  1  one-cycle strobe, `vid_dout` valid
- ram_addr  out  ADDR_W  VRAM address (combinational mux)
- ram_we  out  1  VRAM write enable
- ram_din  out  8  VRAM write data
- ram_dout  in  8  VRAM synchronous read data, 1-cycle latency

Behaviour:
- **Slot decode.** `vid_slot = ~hbl & ~vbl & (h[SLOT_LOG2-1:0]==0)`. All other cycles are free slots.
- **RAM port, video slot.** When `vid_slot` is high: `ram_addr=vid_addr`, `ram_we=0`.
- **RAM port, CPU issue.** When the FSM issues a CPU access: `ram_addr=cpu_addr`, `ram_we=cpu_we`, `ram_din=cpu_din`.
- **RAM port, otherwise.** `ram_addr=cpu_addr`, `ram_we=0`.
- **Video path.**
  - Slot at cycle M: `vid_dout <= ram_dout` at the end of M+1.
  - `vid_valid` is high only during M+2.
  - Independent of the CPU FSM; back-to-back slots pipeline.
- **FSM states:** IDLE, RD, ACK.
- **IDLE:**
  - If `cpu_req & ~vid_slot`: issue access this cycle, go to RD.
  - If `cpu_req & vid_slot`: video wins, stay IDLE.
- **RD:**
  - RAM port is free for video this cycle.
  - Capture `cpu_dout <= ram_dout` on reads only; writes leave `cpu_dout` unchanged.
  - Go to ACK.
- **ACK:** stay until `cpu_req==0`, then go to IDLE. No re-issue while in ACK.
- **`cpu_wait_n`:** combinational, `= ~(cpu_req & state!=ACK)`.
- **Latency.** Best case: request at cycle N in a free slot, wait released at N+2. Worst case during active display adds one cycle per colliding video slot.
- **Write strobe.** `ram_we` is high for exactly one cycle per CPU write and never during a video slot.
- **Request dropped.**
  - If `cpu_req` falls in IDLE: no access is issued.
  - If it falls in RD: complete the capture, go to ACK, then immediately to IDLE.
- **Blanking.** During hbl or vbl every slot is free and the CPU is never stalled beyond the minimum.
- **Reset (synchronous, any state):**
  - state = IDLE.
  - `cpu_dout=0`, `vid_dout=0`, `vid_valid=0`.
  - `ram_we=0`, `cpu_wait_n=1` (given `cpu_req=0`).
  - An in-flight write is not repeated after reset.

Optional Feature:
- Macro `VRAM_WAIT_STATS_EN`.
- **With macro:** adds output `max_wait[7:0]`.
  - Per-request wait counter counts cycles with `cpu_wait_n==0` and `cpu_req==1`, saturating at 255.
  - `max_wait` latches the largest completed count, updated on entry to ACK.
  - Reset clears both the counter and `max_wait`.
- **Without macro:** port and logic are absent; behaviour is otherwise identical.

Decomposition:
- **Package `vram_sched_pkg`:**
  - State enum (IDLE/RD/ACK).
  - Default ADDR_W and SLOT_LOG2 constants.
  - `vid_slot` decode function.
- **Sub-module:** one, `vram_fetch_pipe` (the video capture and `vid_valid` delay pipeline). The FSM stays in the top.

Test Plan:
- **CPU read in vbl.** `vbl=1`, `cpu_req=1`, `cpu_we=0`, `cpu_addr=0x155`, RAM returns 0xA5 → `cpu_wait_n` low for 2 cycles, `cpu_dout=0xA5` at N+2, exactly 1 RAM access.
- **Collision in active display.** `hbl=vbl=0`, request when `h=0x40` (video slot) → first cycle `ram_addr=vid_addr`; CPU issued at `h=0x41`; wait released at `h=0x43`.
- **CPU write.** Write 0x3C to 0x2AA in a free slot → `ram_we` high exactly 1 cycle with `ram_din=0x3C`, `ram_addr=0x2AA`; `cpu_dout` unchanged.
- **Video pipeline.** Slots at `h=0x10`, `0x14`, `0x18` with RAM data 0x11/0x22/0x33 → `vid_valid` pulses at `h=0x12`, `0x16`, `0x1A` with matching `vid_dout`; no pulses while `hbl=1`.
- **Reset mid-write.** `reset=1` during the issue cycle → next cycle state IDLE, `ram_we=0`, `cpu_dout=0`, `vid_valid=0`; with `cpu_req` still high, a new access is issued after reset deasserts.
- **Stats (`VRAM_WAIT_STATS_EN`).** Request stalled by one video slot (3 wait cycles) then an unstalled one (2) → `max_wait=3`, unchanged after the second request.
